// File: rtl/regbank_alu_seq.sv
// regbank_alu_seq
// ---------------
// NREG x W register file (two combinational read ports, one write port plus
// an external load port) driving an 8-opcode ALU behind a valid/ready
// instruction interface. ADD/SUB/AND/OR/XOR/SLT complete at the accepting
// edge. SHL shifts one bit per cycle. MUL, when compiled in, is a W-cycle
// shift-add multiplier. Both iterative ops hold in_ready low until writeback.
//
// Build option:
//   ALU_MUL_EN  - when defined, opcode 111 is the iterative multiplier.
//                 When undefined, opcode 111 completes in one cycle with
//                 err=1, result=0 and no register write.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous reset, active low
//   in_valid   - instruction present
//   in_ready   - instruction can be accepted this cycle
//   opcode     - operation select
//   rd/rs1/rs2 - destination and source register indices
//   ld_en      - external register load strobe (any state)
//   ld_addr    - load target index
//   ld_data    - load value
//   out_valid  - one-cycle pulse when an instruction completes
//   result     - result of the last completed instruction
//   zero/carry/ovf/err - flags of the last completed instruction
//   dbg_addr   - debug read index
//   dbg_data   - combinational read of reg[dbg_addr]

module regbank_alu_seq #(
    parameter int W    = 32,
    parameter int NREG = 16,
    localparam int AW  = $clog2(NREG),
    localparam int SW  = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    opcode,
    input  logic [AW-1:0] rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_data,
    output logic          out_valid,
    output logic [W-1:0]  result,
    output logic          zero,
    output logic          carry,
    output logic          ovf,
    output logic          err,
    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  dbg_data
);

    // Counter is one bit wider than SW so it can hold the full W iterations.
    localparam int CW = SW + 1;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t          state;
    logic [W-1:0]    regs [NREG];
    logic [CW-1:0]   cnt;
    logic [W-1:0]    op_a;
    logic [AW-1:0]   dst;
`ifdef ALU_MUL_EN
    logic [W-1:0]    op_b;
    logic [W-1:0]    acc;
    logic [W-1:0]    mul_next;
`endif

    logic [W-1:0]    a, b;
    logic            fire, is_multi;
    logic [W:0]      sum_ext;
    logic [W-1:0]    alu_res;
    logic            alu_carry, alu_ovf, alu_err, alu_wr;
    logic [W-1:0]    shl_final;

    logic            done;
    logic [W-1:0]    done_res;
    logic            done_carry, done_ovf, done_err;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;

    // Register 0 is never written, so it reads as zero without a special case.
    assign a        = regs[rs1];
    assign b        = regs[rs2];
    assign dbg_data = regs[dbg_addr];

    assign in_ready = (state == IDLE) && !ld_en;
    assign fire     = in_valid && in_ready;

`ifdef ALU_MUL_EN
    assign is_multi = (opcode == 3'b110) || (opcode == 3'b111);
`else
    assign is_multi = (opcode == 3'b110);
`endif

    // The multiplicand shares op_a with the shifter since both move left.
    // A zero shift amount completes with the unshifted operand.
    assign shl_final = (cnt == '0) ? op_a : (op_a << 1);
`ifdef ALU_MUL_EN
    assign mul_next  = acc + (op_b[0] ? op_a : '0);
`endif

    // Single-cycle ALU on the combinational register reads.
    always_comb begin
        sum_ext   = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        alu_wr    = 1'b1;
        case (opcode)
            3'b000: begin
                sum_ext   = {1'b0, a} + {1'b0, b};
                alu_res   = sum_ext[W-1:0];
                alu_carry = sum_ext[W];
                alu_ovf   = (a[W-1] == b[W-1]) && (alu_res[W-1] != a[W-1]);
            end
            3'b001: begin
                alu_res   = a - b;
                alu_carry = (a < b);
                alu_ovf   = (a[W-1] != b[W-1]) && (alu_res[W-1] != a[W-1]);
            end
            3'b010: alu_res = a & b;
            3'b011: alu_res = a | b;
            3'b100: alu_res = a ^ b;
            3'b101: alu_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: begin
                alu_wr = 1'b0;
`ifndef ALU_MUL_EN
                alu_err = (opcode == 3'b111);
`endif
            end
        endcase
    end

    // Completion: decides when an instruction finishes and what it writes.
    always_comb begin
        done       = 1'b0;
        done_res   = '0;
        done_carry = 1'b0;
        done_ovf   = 1'b0;
        done_err   = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = rd;
        case (state)
            IDLE: begin
                if (fire && !is_multi) begin
                    done       = 1'b1;
                    done_res   = alu_res;
                    done_carry = alu_carry;
                    done_ovf   = alu_ovf;
                    done_err   = alu_err;
                    wr_en      = alu_wr;
                    wr_addr    = rd;
                end
            end
            SHIFT: begin
                if (cnt <= CW'(1)) begin
                    done     = 1'b1;
                    done_res = shl_final;
                    wr_en    = 1'b1;
                    wr_addr  = dst;
                end
            end
`ifdef ALU_MUL_EN
            MUL: begin
                if (cnt == CW'(1)) begin
                    done     = 1'b1;
                    done_res = mul_next;
                    wr_en    = 1'b1;
                    wr_addr  = dst;
                end
            end
`endif
            default: ;
        endcase
    end

    // Register file. The load port is applied last so it wins over a
    // writeback to the same address on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (done && wr_en && (wr_addr != '0)) begin
                regs[wr_addr] <= done_res;
            end
            if (ld_en && (ld_addr != '0)) begin
                regs[ld_addr] <= ld_data;
            end
        end
    end

    // Sequencer and registered result/flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_a      <= '0;
            dst       <= '0;
`ifdef ALU_MUL_EN
            op_b      <= '0;
            acc       <= '0;
`endif
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= done;
            if (done) begin
                result <= done_res;
                zero   <= (done_res == '0);
                carry  <= done_carry;
                ovf    <= done_ovf;
                err    <= done_err;
            end
            case (state)
                IDLE: begin
                    if (fire && is_multi) begin
                        op_a <= a;
                        dst  <= rd;
                        if (opcode == 3'b110) begin
                            cnt   <= CW'(b[SW-1:0]);
                            state <= SHIFT;
                        end
`ifdef ALU_MUL_EN
                        else begin
                            op_b  <= b;
                            acc   <= '0;
                            cnt   <= CW'(W);
                            state <= MUL;
                        end
`endif
                    end
                end
                SHIFT: begin
                    if (done) begin
                        state <= IDLE;
                    end else begin
                        op_a <= op_a << 1;
                        cnt  <= cnt - CW'(1);
                    end
                end
`ifdef ALU_MUL_EN
                MUL: begin
                    if (done) begin
                        state <= IDLE;
                    end else begin
                        acc  <= mul_next;
                        op_a <= op_a << 1;
                        op_b <= op_b >> 1;
                        cnt  <= cnt - CW'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
